evt_update_sched: RTL

EVT_UPDATE_SCHED -- requirements
Module: evt_update_sched

---
 rtl/evt_update_sched.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/evt_update_sched.sv
// Event-triggered update scheduler: up to four requesters post values into slots,
// and an event drains the snapped slots round-robin into a shared register.
module evt_update_sched #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic                  ev,
  output logic [WIDTH-1:0]      value,
  output logic                  commit,
  output logic [1:0]            commit_id,
  output logic [NREQ-1:0]       pend,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_DRAIN = 2'b10,
    S_BAD   = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   pend_q, pend_d;
  logic [NREQ-1:0]   snap_q, snap_d;
  logic [1:0]        ptr_q, ptr_d;
  logic              ev_held_q, ev_held_d;
  logic [WIDTH-1:0]  value_q, value_d;
  logic              commit_q, commit_d;
  logic [1:0]        commit_id_q, commit_id_d;
  logic [WIDTH-1:0]  slot_q [NREQ];
  logic [WIDTH-1:0]  slot_d [NREQ];

  logic [NREQ-1:0]   cap;
  logic [NREQ-1:0]   grant_oh;
  logic [NREQ-1:0]   rest;
  logic [1:0]        grant_idx;
  logic [1:0]        scan_idx;
  logic              grant_found;
  logic              do_commit;

  // Rotating priority search over the snapshot, starting at the pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 2'd0;
    scan_idx    = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = ptr_q + 2'(k);
      if (!grant_found && snap_q[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
    do_commit = (state_q == S_DRAIN) && grant_found;
    grant_oh  = do_commit ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
  end

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    ptr_d       = ptr_q;
    ev_held_d   = ev_held_q;
    value_d     = value_q;
    commit_d    = 1'b0;
    commit_id_d = commit_id_q;
    cap         = req & ~pend_q;
    rest        = pend_q & ~grant_oh;
    pend_d      = rest | cap;
    for (int i = 0; i < NREQ; i++) begin
      slot_d[i] = slot_q[i];
      if (cap[i]) slot_d[i] = req_data[i*WIDTH +: WIDTH];
    end

    case (state_q)
      S_IDLE: begin
        if (|cap) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (ev) begin
          state_d = S_DRAIN;
          snap_d  = pend_q;
        end
      end
      S_DRAIN: begin
        if (ev) ev_held_d = 1'b1;
        if (do_commit) begin
          value_d     = slot_q[grant_idx];
          commit_d    = 1'b1;
          commit_id_d = grant_idx;
          snap_d      = snap_q & ~grant_oh;
          ptr_d       = grant_idx + 2'd1;
        end
        // Last snapped slot done: an event seen during the drain re-snaps the leftovers.
        if (snap_d == '0) begin
          ev_held_d = 1'b0;
          if ((ev_held_q || ev) && (|rest)) begin
            state_d = S_DRAIN;
            snap_d  = rest;
          end else if (|pend_d) begin
            state_d = S_ARMED;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        pend_d    = '0;
        snap_d    = '0;
        ev_held_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pend_q      <= '0;
      snap_q      <= '0;
      ptr_q       <= 2'd0;
      ev_held_q   <= 1'b0;
      value_q     <= '0;
      commit_q    <= 1'b0;
      commit_id_q <= 2'd0;
      for (int i = 0; i < NREQ; i++) slot_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      snap_q      <= snap_d;
      ptr_q       <= ptr_d;
      ev_held_q   <= ev_held_d;
      value_q     <= value_d;
      commit_q    <= commit_d;
      commit_id_q <= commit_id_d;
      for (int i = 0; i < NREQ; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign value     = value_q;
  assign commit    = commit_q;
  assign commit_id = commit_id_q;
  assign pend      = pend_q;
  assign state     = state_q;

endmodule
